// File: rtl/env_step.sv
`default_nettype none
// ============================================================================
// env_step : grid-world stepper, action -> reward ROM read -> transition tuple
// Rev 1.0  : initial release
// ============================================================================
module env_step #(
   parameter int ROW_BITS    = 3,
   parameter int COL_BITS    = 3,
   parameter int ACT_BITS    = 2,
   parameter int RWD_WIDTH   = 8,
   parameter int START_STATE = 0,
   parameter int MAX_STEPS   = 64
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic                                  i_start,
   input  logic                                  i_act_valid,
   input  logic [ACT_BITS-1:0]                   i_action,
   output logic                                  o_act_ready,
   output logic [ROW_BITS+COL_BITS+ACT_BITS-1:0] o_rt_addr,
   output logic                                  o_rt_read,
   input  logic [RWD_WIDTH-1:0]                  i_rt_data,
   output logic                                  o_tr_valid,
   input  logic                                  i_tr_ready,
   output logic [ROW_BITS+COL_BITS-1:0]          o_tr_state,
   output logic [ACT_BITS-1:0]                   o_tr_action,
   output logic [RWD_WIDTH-1:0]                  o_tr_reward,
   output logic [ROW_BITS+COL_BITS-1:0]          o_tr_next,
   output logic                                  o_tr_done,
   output logic                                  o_tr_timeout,
   output logic [ROW_BITS+COL_BITS-1:0]          o_cur_state,
   output logic [$clog2(MAX_STEPS)-1:0]          o_step_cnt,
   output logic [15:0]                           o_ep_cnt
);

   localparam int S    = ROW_BITS + COL_BITS;
   localparam int SC_W = $clog2(MAX_STEPS);
   localparam logic [S-1:0]    c_START = S'(START_STATE);
   localparam logic [SC_W-1:0] c_LAST  = SC_W'(MAX_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WT   = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic [S-1:0]          r_cur;
   logic [SC_W-1:0]       r_step;
   logic [15:0]           r_ep;
   logic [ACT_BITS-1:0]   r_act;
   logic [S+ACT_BITS-1:0] r_rt_addr;
   logic                  r_tr_valid;
   logic [S-1:0]          r_tr_state;
   logic [ACT_BITS-1:0]   r_tr_action;
   logic [RWD_WIDTH-1:0]  r_tr_reward;
   logic [S-1:0]          r_tr_next;
   logic                  r_tr_done;
   logic                  r_tr_timeout;

   logic                  w_accept;
   logic                  w_handshake;
   logic [ROW_BITS-1:0]   w_row, w_row_n;
   logic [COL_BITS-1:0]   w_col, w_col_n;
   logic [S-1:0]          w_next;
   logic                  w_goal;
   logic                  w_limit;

   // i_start wins over both handshakes in the same cycle
   assign w_accept    = (r_state == ST_IDLE) && i_act_valid && !i_start;
   assign w_handshake = (r_state == ST_OUT) && i_tr_ready && !i_start;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_act_valid) w_state_nxt = ST_RD;
         ST_RD:   w_state_nxt = ST_WT;
         ST_WT:   w_state_nxt = ST_OUT;
         ST_OUT:  if (i_tr_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      if (i_start) w_state_nxt = ST_IDLE;
   end

   // Successor state: moves off the grid clamp to the current cell
   assign w_row = r_cur[S-1:COL_BITS];
   assign w_col = r_cur[COL_BITS-1:0];

   always_comb begin
      w_row_n = w_row;
      w_col_n = w_col;
      case (r_act[1:0])
         2'b00:   if (w_col != '0) w_col_n = w_col - COL_BITS'(1);
         2'b01:   if (w_row != '0) w_row_n = w_row - ROW_BITS'(1);
         2'b10:   if (w_col != '1) w_col_n = w_col + COL_BITS'(1);
         default: if (w_row != '1) w_row_n = w_row + ROW_BITS'(1);
      endcase
   end

   assign w_next  = {w_row_n, w_col_n};
   assign w_goal  = (w_next == {S{1'b1}});
   assign w_limit = (r_step == c_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cur        <= c_START;
         r_step       <= '0;
         r_ep         <= '0;
         r_act        <= '0;
         r_rt_addr    <= '0;
         r_tr_valid   <= 1'b0;
         r_tr_state   <= '0;
         r_tr_action  <= '0;
         r_tr_reward  <= '0;
         r_tr_next    <= '0;
         r_tr_done    <= 1'b0;
         r_tr_timeout <= 1'b0;
      end else if (i_start) begin
         r_cur      <= c_START;
         r_step     <= '0;
         r_tr_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_act     <= i_action;
            r_rt_addr <= {r_cur, i_action};
         end
         if (r_state == ST_WT) begin
            r_tr_valid   <= 1'b1;
            r_tr_state   <= r_cur;
            r_tr_action  <= r_act;
            r_tr_reward  <= i_rt_data;
            r_tr_next    <= w_next;
            r_tr_done    <= w_goal || w_limit;
            r_tr_timeout <= w_limit && !w_goal;
         end
         if (w_handshake) begin
            r_tr_valid <= 1'b0;
            if (r_tr_done) begin
               r_cur  <= c_START;
               r_step <= '0;
               r_ep   <= r_ep + 16'd1;
            end else begin
               r_cur  <= r_tr_next;
               r_step <= r_step + SC_W'(1);
            end
         end
      end
   end

   assign o_act_ready  = (r_state == ST_IDLE);
   assign o_rt_read    = (r_state == ST_RD);
   assign o_rt_addr    = r_rt_addr;
   assign o_tr_valid   = r_tr_valid;
   assign o_tr_state   = r_tr_state;
   assign o_tr_action  = r_tr_action;
   assign o_tr_reward  = r_tr_reward;
   assign o_tr_next    = r_tr_next;
   assign o_tr_done    = r_tr_done;
   assign o_tr_timeout = r_tr_timeout;
   assign o_cur_state  = r_cur;
   assign o_step_cnt   = r_step;
   assign o_ep_cnt     = r_ep;

endmodule
`default_nettype wire
